// File: rtl/idelay_bank.sv
// Bank of independent tap-programmable delay lines: each channel delays its input
// by 0..2^TAP_W-1 clock cycles, with fixed, adjustable or loadable tap control.
module idelay_bank #(
    parameter int    CHANNELS     = 4,
    parameter int    TAP_W        = 3,
    parameter string IDELAY_TYPE  = "VARIABLE",
    parameter int    IDELAY_VALUE = 0,
    parameter int    PIPE_SEL     = 0
) (
    input  logic                      C,
    input  logic                      RST,
    input  logic [CHANNELS-1:0]       IDATAIN,
    input  logic [CHANNELS-1:0]       CE,
    input  logic [CHANNELS-1:0]       INC,
    input  logic [CHANNELS-1:0]       LD,
    input  logic [CHANNELS-1:0]       LDPIPEEN,
    input  logic [CHANNELS*TAP_W-1:0] CNTVALUEIN,
    output logic [CHANNELS-1:0]       DATAOUT,
    output logic [CHANNELS*TAP_W-1:0] CNTVALUEOUT
);

    localparam int DEPTH = (1 << TAP_W) - 1;
    localparam bit IS_FIXED    = (IDELAY_TYPE == "FIXED");
    localparam bit IS_VAR_LOAD = (IDELAY_TYPE == "VAR_LOAD");
    localparam logic [TAP_W-1:0] INIT_TAP = TAP_W'(IDELAY_VALUE);
    localparam logic [TAP_W-1:0] ONE_TAP  = TAP_W'(1);

    typedef logic [CHANNELS-1:0][TAP_W-1:0] tap_vec_t;
    typedef logic [CHANNELS-1:0][DEPTH-1:0] hist_vec_t;

    if (!(IDELAY_TYPE == "FIXED" || IDELAY_TYPE == "VARIABLE" || IDELAY_TYPE == "VAR_LOAD")) begin : g_bad_type
        $error("idelay_bank: illegal IDELAY_TYPE %s", IDELAY_TYPE);
    end
    if (IDELAY_VALUE < 0 || IDELAY_VALUE > DEPTH) begin : g_bad_value
        $error("idelay_bank: IDELAY_VALUE %0d outside 0..%0d", IDELAY_VALUE, DEPTH);
    end

    tap_vec_t  tap_q, tap_d;
    tap_vec_t  pipe_q, pipe_d;
    tap_vec_t  cnt_in_s;
    hist_vec_t hist_q, hist_d;
    logic [CHANNELS-1:0] dout_s;

    assign cnt_in_s = tap_vec_t'(CNTVALUEIN);

    // Next tap and pipeline value per channel; LD takes priority over CE.
    always_comb begin
        tap_d  = tap_q;
        pipe_d = pipe_q;
        for (int k = 0; k < CHANNELS; k++) begin
            if (IS_FIXED) begin
                tap_d[k] = INIT_TAP;
            end else if (LD[k]) begin
                if (!IS_VAR_LOAD) begin
                    tap_d[k] = INIT_TAP;
                end else if (PIPE_SEL != 0) begin
                    tap_d[k] = pipe_q[k];
                end else begin
                    tap_d[k] = cnt_in_s[k];
                end
            end else if (CE[k]) begin
                if (INC[k]) begin
                    tap_d[k] = tap_q[k] + ONE_TAP;
                end else begin
                    tap_d[k] = tap_q[k] - ONE_TAP;
                end
            end else begin
                tap_d[k] = tap_q[k];
            end

            if (IS_VAR_LOAD && LDPIPEEN[k]) begin
                pipe_d[k] = cnt_in_s[k];
            end else begin
                pipe_d[k] = pipe_q[k];
            end
        end
    end

    // History shift: free-running, independent of tap control.
    always_comb begin
        hist_d = hist_q;
        for (int k = 0; k < CHANNELS; k++) begin
            hist_d[k][0] = IDATAIN[k];
            for (int i = 1; i < DEPTH; i++) begin
                hist_d[k][i] = hist_q[k][i-1];
            end
        end
    end

    // State registers.
    always_ff @(posedge C or posedge RST) begin
        if (RST) begin
            tap_q  <= {CHANNELS{INIT_TAP}};
            pipe_q <= '0;
            hist_q <= '0;
        end else begin
            tap_q  <= tap_d;
            pipe_q <= pipe_d;
            hist_q <= hist_d;
        end
    end

    // Output tap select; tap 0 is a straight pass-through of the live input.
    always_comb begin
        dout_s = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (tap_q[k] == '0) begin
                dout_s[k] = IDATAIN[k];
            end else begin
                dout_s[k] = hist_q[k][tap_q[k] - ONE_TAP];
            end
        end
    end

    assign DATAOUT     = dout_s;
    assign CNTVALUEOUT = tap_q;

endmodule

// File: tb/tb_idelay_bank.sv
// Directed scoreboard bench for idelay_bank in FIXED, VARIABLE and VAR_LOAD configurations.
module tb_idelay_bank;

    logic C, RST;

    // FIXED: 2 channels, tap 2
    logic [1:0] f_din, f_ce, f_inc, f_ld, f_lpe, f_dout;
    logic [5:0] f_cin, f_cnt;
    // VARIABLE: 4 channels, IDELAY_VALUE 2
    logic [3:0]  v_din, v_ce, v_inc, v_ld, v_lpe, v_dout;
    logic [11:0] v_cin, v_cnt;
    // VAR_LOAD: 2 channels, IDELAY_VALUE 0, PIPE_SEL 1
    logic [1:0] l_din, l_ce, l_inc, l_ld, l_lpe, l_dout;
    logic [5:0] l_cin, l_cnt;

    idelay_bank #(.CHANNELS(2), .TAP_W(3), .IDELAY_TYPE("FIXED"), .IDELAY_VALUE(2), .PIPE_SEL(0)) u_fix (
        .C(C), .RST(RST), .IDATAIN(f_din), .CE(f_ce), .INC(f_inc), .LD(f_ld),
        .LDPIPEEN(f_lpe), .CNTVALUEIN(f_cin), .DATAOUT(f_dout), .CNTVALUEOUT(f_cnt));

    idelay_bank #(.CHANNELS(4), .TAP_W(3), .IDELAY_TYPE("VARIABLE"), .IDELAY_VALUE(2), .PIPE_SEL(0)) u_var (
        .C(C), .RST(RST), .IDATAIN(v_din), .CE(v_ce), .INC(v_inc), .LD(v_ld),
        .LDPIPEEN(v_lpe), .CNTVALUEIN(v_cin), .DATAOUT(v_dout), .CNTVALUEOUT(v_cnt));

    idelay_bank #(.CHANNELS(2), .TAP_W(3), .IDELAY_TYPE("VAR_LOAD"), .IDELAY_VALUE(0), .PIPE_SEL(1)) u_vld (
        .C(C), .RST(RST), .IDATAIN(l_din), .CE(l_ce), .INC(l_inc), .LD(l_ld),
        .LDPIPEEN(l_lpe), .CNTVALUEIN(l_cin), .DATAOUT(l_dout), .CNTVALUEOUT(l_cnt));

    initial C = 1'b0;
    always #5 C = ~C;

    typedef struct {
        int          due;
        int          sel;
        logic [31:0] exp;
        string       tag;
    } sb_t;

    sb_t sb[$];
    int  cyc    = 0;
    int  checks = 0;
    int  errors = 0;

    function automatic logic [31:0] obs(input int sel);
        case (sel)
            0: return 32'(f_dout);
            1: return 32'(f_cnt);
            2: return 32'(v_dout);
            3: return 32'(v_cnt);
            4: return 32'(l_dout);
            5: return 32'(l_cnt);
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic [11:0] p4(input logic [2:0] t3, input logic [2:0] t2,
                                       input logic [2:0] t1, input logic [2:0] t0);
        return {t3, t2, t1, t0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    task automatic push(input int due, input int sel, input logic [31:0] e, input string tag);
        sb_t it;
        it.due = due; it.sel = sel; it.exp = e; it.tag = tag;
        sb.push_back(it);
    endtask

    task automatic step();
        @(posedge C);
        #1;
        cyc++;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                chk($sformatf("%s@%0d", sb[i].tag, cyc), obs(sb[i].sel), sb[i].exp);
                sb.delete(i);
            end
        end
    endtask

    initial begin
        RST = 1'b1;
        f_din = 2'b11; f_ce = '0; f_inc = '0; f_ld = '0; f_lpe = '0; f_cin = '0;
        v_din = 4'hF;  v_ce = '0; v_inc = '0; v_ld = '0; v_lpe = '0; v_cin = '0;
        l_din = 2'b10; l_ce = '0; l_inc = '0; l_ld = '0; l_lpe = '0; l_cin = '0;

        // Reset state: history zero, taps at IDELAY_VALUE, tap-0 channels pass through
        push(1, 0, 32'h0,   "rst_f_dout");
        push(1, 1, 32'o22,  "rst_f_cnt");
        push(1, 2, 32'h0,   "rst_v_dout");
        push(1, 3, 32'(p4(3'd2, 3'd2, 3'd2, 3'd2)), "rst_v_cnt");
        push(1, 4, 32'h2,   "rst_l_dout");
        push(1, 5, 32'h0,   "rst_l_cnt");
        step();
        RST = 1'b0;
        f_din = '0; v_din = '0; l_din = '0;
        step();

        // Fixed delay: one-cycle pulse, controls toggling must not move the tap
        f_din = 2'b01; f_ce = 2'b11; f_ld = 2'b11; f_inc = 2'b11; f_lpe = 2'b11; f_cin = 6'h3F;
        for (int k = 1; k <= 4; k++) begin
            push(cyc + k, 0, (k == 2) ? 32'h1 : 32'h0, "fix_dout");
            push(cyc + k, 1, 32'o22, "fix_cnt");
        end
        step();
        f_din = '0; f_ld = 2'b00; f_inc = 2'b00;
        step();
        f_ce = 2'b00; f_ld = 2'b11;
        step();
        step();

        // Walk channel 0 of the VARIABLE bank up to tap 7
        v_ce = 4'b0001; v_inc = 4'b0001;
        for (int i = 1; i <= 5; i++) begin
            push(cyc + 1, 3, 32'(p4(3'd2, 3'd2, 3'd2, 3'(2 + i))), "v_inc");
            step();
        end

        // Wrap up 7 -> 0: pass-through
        push(cyc + 1, 3, 32'(p4(3'd2, 3'd2, 3'd2, 3'd0)), "wrap_up_cnt");
        step();
        v_ce = '0;
        v_din = 4'b0001; #1;
        chk("wrap_pass_hi", 32'(v_dout), 32'h1);
        v_din = 4'b0000; #1;
        chk("wrap_pass_lo", 32'(v_dout), 32'h0);

        // Wrap down 0 -> 7, then a pulse must lag 7 cycles
        v_ce = 4'b0001; v_inc = 4'b0000;
        push(cyc + 1, 3, 32'(p4(3'd2, 3'd2, 3'd2, 3'd7)), "wrap_dn_cnt");
        step();
        v_ce = '0;
        v_din = 4'b0001;
        for (int k = 1; k <= 8; k++) begin
            push(cyc + k, 2, (k == 7) ? 32'h1 : 32'h0, "lag7_dout");
        end
        step();
        v_din = '0;
        for (int k = 0; k < 7; k++) step();

        // Priority: tap 5, LD with CE/INC -> IDELAY_VALUE
        v_ce = 4'b0001; v_inc = 4'b0000;
        push(cyc + 1, 3, 32'(p4(3'd2, 3'd2, 3'd2, 3'd6)), "dec_cnt");
        push(cyc + 2, 3, 32'(p4(3'd2, 3'd2, 3'd2, 3'd5)), "dec_cnt");
        step();
        step();
        v_ld = 4'b0001; v_inc = 4'b0001;
        push(cyc + 1, 3, 32'(p4(3'd2, 3'd2, 3'd2, 3'd2)), "prio_cnt");
        step();
        v_ld = '0;

        // Channel isolation
        v_ce = 4'b0010; v_inc = 4'b0010;
        push(cyc + 1, 3, 32'(p4(3'd2, 3'd2, 3'd3, 3'd2)), "iso1_cnt");
        step();
        v_ce = 4'b0100; v_inc = 4'b0000;
        push(cyc + 1, 3, 32'(p4(3'd2, 3'd1, 3'd3, 3'd2)), "iso2_cnt");
        step();
        v_ce = '0;

        // Fill history with ones under mixed taps (3:2, 2:1, 1:3, 0:2)
        v_din = 4'hF;
        push(cyc + 2, 2, 32'hD, "mix_dout");
        push(cyc + 3, 2, 32'hF, "mix_dout");
        step();
        step();
        step();

        // Mid-stream reset with pending adjustments
        RST = 1'b1; v_ce = 4'b0011; v_inc = 4'b0011;
        #1;
        chk("midrst_cnt",  32'(v_cnt),  32'(p4(3'd2, 3'd2, 3'd2, 3'd2)));
        chk("midrst_dout", 32'(v_dout), 32'h0);
        push(cyc + 1, 3, 32'(p4(3'd2, 3'd2, 3'd2, 3'd2)), "inrst_cnt");
        push(cyc + 1, 2, 32'h0, "inrst_dout");
        step();
        RST = 1'b0; v_ce = '0;
        push(cyc + 1, 2, 32'h0, "postrst_dout");
        push(cyc + 1, 3, 32'(p4(3'd2, 3'd2, 3'd2, 3'd2)), "postrst_cnt");
        push(cyc + 2, 2, 32'hF, "refill_dout");
        step();
        step();

        // VAR_LOAD with PIPE_SEL=1: pipe capture, simultaneous LD+LDPIPEEN
        l_lpe = 2'b01; l_cin = {3'd0, 3'd3};
        push(cyc + 1, 5, 32'h0, "pipe_cap_cnt");
        step();
        l_ld = 2'b01; l_lpe = 2'b01; l_cin = {3'd0, 3'd6};
        push(cyc + 1, 5, 32'({3'd0, 3'd3}), "pipe_ld_old");
        step();
        l_lpe = 2'b00; l_cin = {3'd0, 3'd1};
        push(cyc + 1, 5, 32'({3'd0, 3'd6}), "pipe_ld_new");
        step();
        l_ld = '0;
        l_ce = 2'b10; l_inc = 2'b00;
        push(cyc + 1, 5, 32'({3'd7, 3'd6}), "vld_dec_wrap");
        step();
        l_ce = 2'b01; l_inc = 2'b01;
        push(cyc + 1, 5, 32'({3'd7, 3'd7}), "vld_inc");
        push(cyc + 2, 5, 32'({3'd7, 3'd0}), "vld_inc_wrap");
        step();
        step();
        l_ce = '0;
        l_din = 2'b01; #1;
        chk("vld_pass", 32'(l_dout), 32'h1);
        l_din = '0;

        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
